// File: rtl/cdc_bundled_rx.sv
// cdc_bundled_rx: receive side of a four-phase bundled-data req/ack handshake.
// The request is synchronized into clk and the payload is captured once req is
// stable. The word is offered on valid/ready, and ack returns to the sender only
// after the local consumer has taken the word, so backpressure reaches the sender.
// SYNC_STAGES must be in the range 2..4.
module cdc_bundled_rx #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ack_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
    output logic                  proto_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_t;

    // All registered outputs travel together so next-state logic can default
    // them with a single hold assignment.
    typedef struct packed {
        logic                  valid;
        logic                  ack;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
        logic [CNT_WIDTH-1:0]  cnt;
    } rx_regs_t;

    state_t                 state_q, state_d;
    rx_regs_t               regs_q, regs_d;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;

    assign req_s = req_sync[SYNC_STAGES-1];

    // Shift req_i through the synchronizer chain; only the last stage is used.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) req_sync <= '0;
        else         req_sync <= {req_sync[SYNC_STAGES-2:0], req_i};
    end

    // Next-state and next-output logic. The payload is only sampled in IDLE,
    // after req_s is high, which guarantees data_i has been stable for at least
    // SYNC_STAGES cycles.
    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    regs_d.data  = data_i;
                    regs_d.valid = 1'b1;
                    state_d      = VALID;
                end
            end
            VALID: begin
                // An accept on the same edge as a withdrawal still counts as a
                // normal transfer; ACK then sees req_s low and releases.
                if (ready_i) begin
                    regs_d.valid = 1'b0;
                    regs_d.ack   = 1'b1;
                    regs_d.cnt   = regs_q.cnt + 1'b1;
                    state_d      = ACK;
                end else if (!req_s) begin
                    regs_d.valid = 1'b0;
                    regs_d.err   = 1'b1;
                    state_d      = IDLE;
                end
            end
            ACK: begin
                // Returning to IDLE only after req_s drops means one request
                // can never be captured twice.
                if (!req_s) begin
                    regs_d.ack = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                regs_d.valid = 1'b0;
                regs_d.ack   = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending word immediately.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            regs_q  <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
        end
    end

    assign ack_o       = regs_q.ack;
    assign valid_o     = regs_q.valid;
    assign data_o      = regs_q.data;
    assign xfer_cnt_o  = regs_q.cnt;
    assign proto_err_o = regs_q.err;

endmodule

// File: tb/tb_cdc_bundled_rx.sv
// Bench for cdc_bundled_rx: directed vector table, random sender/consumer
// against a queue-based reference, withdrawal, counter wrap and mid-op reset.
module tb_cdc_bundled_rx;

    localparam int SS = 2;

    logic        clk, reset_i, req_i, ready_i;
    logic [31:0] data_i;
    logic        ack_o, valid_o, proto_err_o;
    logic [31:0] data_o;
    logic [15:0] xfer_cnt_o;
    logic        w_ack, w_valid, w_err;
    logic [31:0] w_data;
    logic [3:0]  w_cnt;

    int nchk = 0;
    int nerr = 0;

    cdc_bundled_rx #(.DATA_WIDTH(32), .SYNC_STAGES(SS), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset_i(reset_i), .req_i(req_i), .data_i(data_i),
        .ack_o(ack_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
        .xfer_cnt_o(xfer_cnt_o), .proto_err_o(proto_err_o)
    );

    // Narrow-counter copy sharing all inputs, used for the wrap case.
    cdc_bundled_rx #(.DATA_WIDTH(32), .SYNC_STAGES(SS), .CNT_WIDTH(4)) u_wrap (
        .clk(clk), .reset_i(reset_i), .req_i(req_i), .data_i(data_i),
        .ack_o(w_ack), .valid_o(w_valid), .data_o(w_data), .ready_i(ready_i),
        .xfer_cnt_o(w_cnt), .proto_err_o(w_err)
    );

    // Period 20: posedges at 10+20k, negedges at 20k; the async sender only
    // moves at odd times so it never lands on a clk edge.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1; req_i = 1'b0; ready_i = 1'b0; data_i = '0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    // One synchronous-side transfer: ready held low for wcyc valid cycles.
    // lat/rel are counted in negedges from the req change.
    task automatic xfer(input logic [31:0] d, input int wcyc, output int lat,
                        output int vcyc, output int rel, output bit bad, output bit acc);
        bad = 1'b0;
        @(negedge clk);
        data_i = d; ready_i = (wcyc == 0); req_i = 1'b1;
        lat = 0;
        while (!valid_o && lat < 50) begin @(negedge clk); lat++; end
        vcyc = 0;
        while (valid_o && vcyc < 100) begin
            if (data_o !== d || ack_o !== 1'b0) bad = 1'b1;
            vcyc++;
            if (vcyc > wcyc) ready_i = 1'b1;
            @(negedge clk);
        end
        acc = ack_o;
        ready_i = 1'b0; req_i = 1'b0;
        rel = 0;
        while (ack_o && rel < 50) begin @(negedge clk); rel++; end
    endtask

    typedef struct {
        logic [31:0] data;
        int          wait_cyc;
        int          exp_vcyc;
        int          exp_cnt;
    } vec_t;

    vec_t        vec[5];
    logic [31:0] exp_q[$];
    bit          snd_done;

    initial begin
        int  lat, vcyc, rel, n, got, cnt_model, caps;
        bit  bad, acc, ack_seen;

        vec[0] = '{32'hDEADBEEF, 0,  1,  1};
        vec[1] = '{32'h12345678, 10, 11, 2};
        vec[2] = '{32'h00000000, 0,  1,  3};
        vec[3] = '{32'hFFFFFFFF, 3,  4,  4};
        vec[4] = '{32'hA5A5A5A5, 1,  2,  5};

        reset_i = 1'b1; req_i = 1'b0; ready_i = 1'b0; data_i = '0;
        #25;
        check("rst_ack", ack_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_cnt", xfer_cnt_o, 0);
        check("rst_err", proto_err_o, 0);
        check("rst_wcnt", w_cnt, 0);
        do_reset();

        // Directed table
        for (int i = 0; i < 5; i++) begin
            xfer(vec[i].data, vec[i].wait_cyc, lat, vcyc, rel, bad, acc);
            check($sformatf("v%0d_lat", i), lat, SS + 1);
            check($sformatf("v%0d_vcyc", i), vcyc, vec[i].exp_vcyc);
            check($sformatf("v%0d_hold", i), bad, 0);
            check($sformatf("v%0d_ack_on_accept", i), acc, 1);
            check($sformatf("v%0d_cnt", i), xfer_cnt_o, vec[i].exp_cnt);
            check($sformatf("v%0d_rel", i), rel, SS + 1);
            repeat (3) @(negedge clk);
        end
        check("tbl_err", proto_err_o, 0);

        // Random async sender vs random consumer, reference is a FIFO of sent words
        do_reset();
        snd_done = 1'b0;
        got = 0;
        cnt_model = 0;
        fork
            begin : sender
                int p, t;
                bit to;
                p = 2 * $urandom_range(3, 30);
                to = 1'b0;
                #1;
                for (int w = 0; w < 1000 && !to; w++) begin
                    data_i = w;
                    #(p);
                    req_i = 1'b1;
                    exp_q.push_back(w);
                    t = 0;
                    while (!ack_o && t < 4000) begin #2; t++; end
                    if (t >= 4000) to = 1'b1;
                    #(p);
                    req_i = 1'b0;
                    t = 0;
                    while (ack_o && t < 4000) begin #2; t++; end
                    if (t >= 4000) to = 1'b1;
                    #(2 * $urandom_range(0, 5));
                end
                check("rnd_sender_timeout", to, 0);
                snd_done = 1'b1;
            end
            begin : consumer
                int cyc;
                cyc = 0;
                while (!(snd_done && exp_q.size() == 0) && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    ready_i = ($urandom_range(0, 3) != 0);
                    if (valid_o && ready_i) begin
                        got++;
                        if (exp_q.size() == 0) check("rnd_extra_word", 1, 0);
                        else begin
                            check("rnd_data", data_o, exp_q.pop_front());
                            cnt_model++;
                        end
                    end
                end
                check("rnd_consumer_timeout", cyc < 40000, 1);
            end
        join
        ready_i = 1'b0;
        repeat (5) @(negedge clk);
        check("rnd_got", got, 1000);
        check("rnd_cnt", xfer_cnt_o, cnt_model);
        check("rnd_cnt_1000", xfer_cnt_o, 1000);
        check("rnd_err", proto_err_o, 0);

        // Withdrawal while valid and not ready
        @(negedge clk);
        data_i = 32'hC0FFEE00; ready_i = 1'b0; req_i = 1'b1;
        n = 0;
        while (!valid_o && n < 50) begin @(negedge clk); n++; end
        check("wd_valid", valid_o, 1);
        check("wd_data", data_o, 32'hC0FFEE00);
        req_i = 1'b0;
        ack_seen = 1'b0;
        n = 0;
        while (valid_o && n < 50) begin @(negedge clk); n++; if (ack_o) ack_seen = 1'b1; end
        check("wd_fall", n, SS + 1);
        check("wd_err", proto_err_o, 1);
        check("wd_noack", ack_seen, 0);
        check("wd_cnt", xfer_cnt_o, 1000);
        ready_i = 1'b1;
        repeat (8) @(negedge clk);
        check("wd_err_sticky", proto_err_o, 1);
        check("wd_idle", valid_o | ack_o, 0);

        // Counter wrap on the narrow copy
        do_reset();
        for (int i = 0; i < 17; i++) xfer(32'h100 + i, i % 3, lat, vcyc, rel, bad, acc);
        check("wrap_cnt4", w_cnt, 1);
        check("wrap_cnt16", xfer_cnt_o, 17);
        check("wrap_err_cleared", proto_err_o, 0);

        // Reset while in ACK with req still high
        do_reset();
        @(negedge clk);
        data_i = 32'h600DF00D; ready_i = 1'b1; req_i = 1'b1;
        n = 0;
        while (!ack_o && n < 50) begin @(negedge clk); n++; end
        check("rsta_in_ack", ack_o, 1);
        #2 reset_i = 1'b1;
        #1;
        check("rsta_ack_low", ack_o, 0);
        check("rsta_valid_low", valid_o, 0);
        check("rsta_cnt_zero", xfer_cnt_o, 0);
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0; ready_i = 1'b0;
        caps = 0;
        n = 0;
        while (!valid_o && n < 50) begin @(negedge clk); n++; end
        check("rsta_recapture", valid_o, 1);
        check("rsta_data", data_o, 32'h600DF00D);
        ready_i = 1'b1;
        if (valid_o) caps++;
        @(negedge clk);
        check("rsta_ack", ack_o, 1);
        check("rsta_cnt", xfer_cnt_o, 1);
        repeat (6) begin @(negedge clk); if (valid_o) caps++; end
        req_i = 1'b0;
        repeat (10) begin @(negedge clk); if (valid_o) caps++; end
        check("rsta_one_capture", caps, 1);
        check("rsta_released", ack_o, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
